reg_dump_controller: RTL
========================

REG_DUMP_CONTROLLER -- requirements
Module: reg_dump_controller

Interface
REQ-001 Parameter START_REG, default 0; index of the first register dumped.
REQ-002 Parameter END_REG, default 31; index of the last register dumped.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 abort  input  1  terminates any dump in progress.
REQ-007 dbg_reg_addr  output  5  drives the core debug register read address.
REQ-008 dbg_reg_data  input  32  combinational read data from the core debug port.
REQ-009 out_valid  output  1  output beat valid.
REQ-010 out_ready  input  1  consumer accepts the beat when out_valid and out_ready are both high.
REQ-011 out_addr  output  5  register index of the current beat.
REQ-012 out_data  output  32  register value (or checksum) of the current beat.
REQ-013 out_last  output  1  marks the final beat of a dump.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse on normal completion.

Function
REQ-016 The FSM SHALL have states IDLE, READ, HOLD, CHK and DONE; CHK is present only when the macro in REQ-032 is defined.
REQ-017 IDLE: start=1 and abort=0 SHALL load the index counter with START_REG and enter READ on the next edge.
REQ-018 dbg_reg_addr SHALL always equal the index counter (registered, glitch-free).
REQ-019 READ: out_data <= dbg_reg_data, out_addr <= index; next state HOLD, with out_valid=1 in HOLD.
REQ-020 First out_valid SHALL assert exactly 2 cycles after the cycle start is sampled.
REQ-021 HOLD: out_valid, out_addr, out_data and out_last SHALL stay stable until the handshake completes.
REQ-022 HOLD with handshake and index != END_REG: index += 1, next state READ; the per-beat minimum is 2 cycles.
REQ-023 HOLD with handshake and index == END_REG: next state CHK if enabled, else DONE.
REQ-024 Without the macro, out_last SHALL be 1 in HOLD when index == END_REG, and 0 otherwise.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; done SHALL be 0 in all other states.
REQ-026 start while busy SHALL be ignored and SHALL NOT restart the dump.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with out_valid=0 and no done pulse; abort has priority over start and over a simultaneous handshake.
REQ-028 START_REG == END_REG SHALL produce exactly one data beat; START_REG > END_REG or values > 31 are a compile-time error (elaboration check).
REQ-029 The index counter is 5 bits and SHALL never wrap, since the END_REG compare occurs first.
REQ-030 Register values are sampled in each READ cycle; dump atomicity is not guaranteed while the core runs.

Reset
REQ-031 reset=1 SHALL immediately force IDLE, with index=START_REG, out_valid=0, out_addr=0, out_data=0, out_last=0, busy=0 and done=0; a reset mid-dump discards it.

Configuration
REQ-032 Macro REG_DUMP_CHECKSUM_EN defined: a running XOR of all dumped data is cleared on start.
- After the END_REG beat, CHK SHALL present one extra beat with out_data=XOR, out_addr=END_REG and out_last=1, then go to DONE on handshake.
- Register beats then have out_last=0.
REQ-033 Macro REG_DUMP_CHECKSUM_EN undefined: there is no CHK state and no XOR register, and out_last is per REQ-024.

Verification
REQ-034 Default parameters, out_ready=1, x(i)=i*0x11111111 -> 32 beats with addr 0..31, data correct, beat spacing 2 cycles, out_last only on addr 31, done 1 cycle after the last handshake.
REQ-035 START_REG=5, END_REG=5, x5=0xDEADBEEF -> a single beat addr=5, data=0xDEADBEEF, out_last=1 (checksum build: a second beat with data=0xDEADBEEF).
REQ-036 out_ready held 0 for 10 cycles at beat 3 -> beat 3 outputs stable for all 10 cycles; the dbg_reg_addr advance occurs only after acceptance.
REQ-037 abort asserted in the same cycle as the handshake of beat 7 -> IDLE next cycle, out_valid=0, done never pulses, busy=0.
REQ-038 reset asserted mid-HOLD, asynchronously between edges -> outputs are zero immediately; start pulsed while busy produces no restart (index continues).
REQ-039 Checksum build, x1=0xF0F0F0F0, x2=0x0F0F0F0F, START_REG=1, END_REG=2 -> a checksum beat with data=0xFFFFFFFF, out_last=1.

Source files
------------

// File: rtl/reg_dump_controller.sv
// reg_dump_controller: walks core debug registers START_REG..END_REG and
// streams each one out as a valid/ready beat (index + value).
// Optional feature macro REG_DUMP_CHECKSUM_EN: appends one XOR checksum
// beat after the last register and moves out_last onto that beat.
module reg_dump_controller #(
    parameter int START_REG = 0,
    parameter int END_REG   = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  dbg_reg_addr,
    input  logic [31:0] dbg_reg_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] START_IDX = 5'(START_REG);
    localparam logic [4:0] END_IDX   = 5'(END_REG);

    // Reject ranges the 5-bit index cannot walk forward through.
    generate
        if (START_REG < 0 || END_REG > 31 || START_REG > END_REG) begin : g_bad_range
            $error("reg_dump_controller: need 0 <= START_REG <= END_REG <= 31");
        end
    endgenerate

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, READ, HOLD, CHK, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;
`endif

    state_t     state, nxt;
    logic [4:0] idx;
    logic       hs;
    logic       at_end;
    logic       go;

    assign hs     = out_valid & out_ready;
    assign at_end = (idx == END_IDX);
    assign go     = (state == IDLE) & start & ~abort;

    // Read address comes straight from the index flop, so it never glitches.
    assign dbg_reg_addr = idx;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // Next-state and state-decoded outputs; abort overrides everything.
    always_comb begin
        nxt       = state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: if (start) nxt = READ;
            READ: nxt = HOLD;
            HOLD: begin
                out_valid = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                if (hs) nxt = at_end ? CHK : READ;
`else
                out_last = at_end;
                if (hs) nxt = at_end ? DONE : READ;
`endif
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CHK: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                if (hs) nxt = DONE;
            end
`endif
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end

    // Index counter: loaded on start, bumped only after a beat is accepted
    // and only below END_REG, so it never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idx <= START_IDX;
        else if (go)
            idx <= START_IDX;
        else if (state == HOLD && hs && !at_end && !abort)
            idx <= idx + 5'd1;
    end

`ifdef REG_DUMP_CHECKSUM_EN
    logic [31:0] csum;

    // Running XOR of every register value captured during this dump.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            csum <= '0;
        else if (go)
            csum <= '0;
        else if (state == READ && !abort)
            csum <= csum ^ dbg_reg_data;
    end
`endif

    // Beat payload: captured in READ, held through HOLD; in the checksum
    // build the final register handshake swaps in the XOR for the CHK beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_addr <= '0;
            out_data <= '0;
        end else if (state == READ && !abort) begin
            out_addr <= idx;
            out_data <= dbg_reg_data;
        end
`ifdef REG_DUMP_CHECKSUM_EN
        else if (state == HOLD && hs && at_end && !abort) begin
            out_data <= csum;
        end
`endif
    end

endmodule
